// File: rtl/csr_commit.sv
// csr_commit -- serialising commit stage in front of the CSR register file.
//
// Accepts one SYSTEM-class instruction at a time (CSRRW/S/C[I], ECALL, MRET).
// It computes the read-modify-write value and publishes a writer record. The
// CSR file applies the record when wr_inst_counter changes. The stage then
// flushes the pipeline and redirects fetch, so younger instructions see the
// updated CSR state.
//
// Sequence: IDLE -(accept)-> APPLY (1 cycle) -> FLUSH (FLUSH_CYCLES) -> IDLE
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_*                 instruction offered by writeback (valid/ready)
//   csr_old_value        current value of in_csr_addr (combinational read)
//   csr_mtvec/csr_mepc   current trap vector / exception pc
//   wr_*                 CSR writer record, registered at accept and held
//   rd_valid/rd_value    old CSR value for rd writeback (1-cycle pulse)
//   flush/redirect_*     pipeline flush and fetch redirect during FLUSH
//
// Optional build macro CSR_COMMIT_PERF_EN adds the perf_commits and
// perf_traps counters (accepted instructions / accepted ECALLs).

module csr_commit #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_funct3,
    input  logic [11:0]     in_csr_addr,
    input  logic [4:0]      in_rs1_idx,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic            in_is_ecall,
    input  logic            in_is_mret,
    input  logic [XLEN-1:0] csr_old_value,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic [XLEN-1:0] wr_inst_counter,
    output logic [XLEN-1:0] wr_pc,
    output logic            wr_ecall,
    output logic            wr_mret,
    output logic            wr_csr_write_enable,
    output logic            wr_plain,
    output logic [11:0]     wr_csr_dest_addr,
    output logic [XLEN-1:0] wr_csr_write_data,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_value,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
`ifdef CSR_COMMIT_PERF_EN
    ,
    output logic [XLEN-1:0] perf_commits,
    output logic [XLEN-1:0] perf_traps
`endif
);

    localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_FLUSH
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   fcnt;
    logic            accept;

    logic [XLEN-1:0] src;
    logic [XLEN-1:0] new_value;
    logic [XLEN-1:0] target;
    logic            is_csr_op;
    logic            write_en;

    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] target_q;
    logic            rd_pend_q;

    // Datapath for the instruction currently offered; only used on accept.
    always_comb begin
        src       = in_funct3[2] ? {{(XLEN-5){1'b0}}, in_rs1_idx} : in_rs1_val;
        new_value = '0;
        unique case (in_funct3[1:0])
            2'b01:   new_value = src;
            2'b10:   new_value = csr_old_value | src;
            2'b11:   new_value = csr_old_value & ~src;
            default: new_value = '0;
        endcase

        // ECALL and MRET take precedence over whatever funct3 carries.
        is_csr_op = !in_is_ecall && !in_is_mret && (in_funct3[1:0] != 2'b00);
        // RS/RC with rs1=x0 (or zimm=0) must not write: they are pure reads.
        write_en  = is_csr_op && ((in_funct3[1:0] == 2'b01) || (in_rs1_idx != 5'd0));

        if (in_is_ecall)
            target = csr_mtvec & ~XLEN'(3);
        else if (in_is_mret)
            target = csr_mepc;
        else
            target = in_pc + XLEN'(4);
    end

    // Next-state and stage outputs.
    always_comb begin
        state_next     = state;
        in_ready       = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rd_valid       = 1'b0;
        rd_value       = '0;

        unique case (state)
            S_IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst)
                    state_next = S_APPLY;
            end
            S_APPLY: begin
                state_next = S_FLUSH;
            end
            S_FLUSH: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                if (fcnt == '0 && rd_pend_q) begin
                    rd_valid = 1'b1;
                    rd_value = old_q;
                end
                if (fcnt == CW'(FLUSH_CYCLES - 1))
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        accept = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            fcnt                <= '0;
            wr_inst_counter     <= '0;
            wr_pc               <= '0;
            wr_ecall            <= 1'b0;
            wr_mret             <= 1'b0;
            wr_csr_write_enable <= 1'b0;
            wr_plain            <= 1'b0;
            wr_csr_dest_addr    <= '0;
            wr_csr_write_data   <= '0;
            old_q               <= '0;
            target_q            <= '0;
            rd_pend_q           <= 1'b0;
`ifdef CSR_COMMIT_PERF_EN
            perf_commits        <= '0;
            perf_traps          <= '0;
`endif
        end else begin
            state <= state_next;
            fcnt  <= (state == S_FLUSH) ? fcnt + 1'b1 : '0;
            if (accept) begin
                wr_inst_counter     <= wr_inst_counter + 1'b1;
                wr_pc               <= in_pc;
                wr_ecall            <= in_is_ecall;
                wr_mret             <= in_is_mret && !in_is_ecall;
                wr_csr_write_enable <= write_en;
                wr_plain            <= write_en;
                wr_csr_dest_addr    <= in_csr_addr;
                wr_csr_write_data   <= is_csr_op ? new_value : '0;
                old_q               <= csr_old_value;
                target_q            <= target;
                rd_pend_q           <= is_csr_op;
`ifdef CSR_COMMIT_PERF_EN
                perf_commits        <= perf_commits + 1'b1;
                if (in_is_ecall)
                    perf_traps <= perf_traps + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_csr_commit.sv
// Testbench for csr_commit: directed cases plus randomized transactions,
// checked against a behavioural model of the commit rules.

module tb_csr_commit;

    localparam int unsigned XLEN         = 64;
    localparam int unsigned FLUSH_CYCLES = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [2:0]      in_funct3;
    logic [11:0]     in_csr_addr;
    logic [4:0]      in_rs1_idx;
    logic [XLEN-1:0] in_rs1_val;
    logic            in_is_ecall;
    logic            in_is_mret;
    logic [XLEN-1:0] csr_old_value;
    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mepc;
    logic [XLEN-1:0] wr_inst_counter;
    logic [XLEN-1:0] wr_pc;
    logic            wr_ecall;
    logic            wr_mret;
    logic            wr_csr_write_enable;
    logic            wr_plain;
    logic [11:0]     wr_csr_dest_addr;
    logic [XLEN-1:0] wr_csr_write_data;
    logic            rd_valid;
    logic [XLEN-1:0] rd_value;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
`ifdef CSR_COMMIT_PERF_EN
    logic [XLEN-1:0] perf_commits;
    logic [XLEN-1:0] perf_traps;
`endif

    csr_commit #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_funct3(in_funct3), .in_csr_addr(in_csr_addr),
        .in_rs1_idx(in_rs1_idx), .in_rs1_val(in_rs1_val),
        .in_is_ecall(in_is_ecall), .in_is_mret(in_is_mret),
        .csr_old_value(csr_old_value), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .wr_inst_counter(wr_inst_counter), .wr_pc(wr_pc),
        .wr_ecall(wr_ecall), .wr_mret(wr_mret),
        .wr_csr_write_enable(wr_csr_write_enable), .wr_plain(wr_plain),
        .wr_csr_dest_addr(wr_csr_dest_addr), .wr_csr_write_data(wr_csr_write_data),
        .rd_valid(rd_valid), .rd_value(rd_value),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef CSR_COMMIT_PERF_EN
        , .perf_commits(perf_commits), .perf_traps(perf_traps)
`endif
    );

    always #5 clk = ~clk;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    // Reference model state: what the writer record and FLUSH outputs must show.
    logic [63:0] m_cnt, m_pc, m_data, m_old, m_target;
    logic [11:0] m_addr;
    logic        m_ecall, m_mret, m_we, m_is_csr;
    logic [63:0] m_commits, m_traps;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_pc = 0; m_data = 0; m_old = 0; m_target = 0; m_addr = 0;
        m_ecall = 0; m_mret = 0; m_we = 0; m_is_csr = 0;
        m_commits = 0; m_traps = 0;
    endtask

    // Commit rules expressed per instruction kind, not per datapath signal.
    task automatic model_accept(input logic [63:0] pc, input logic [2:0] f3,
                                input logic [11:0] addr, input logic [4:0] idx,
                                input logic [63:0] val, input logic ec, input logic mr,
                                input logic [63:0] old, input logic [63:0] mtvec,
                                input logic [63:0] mepc);
        logic [63:0] operand;
        m_cnt     = m_cnt + 1;
        m_commits = m_commits + 1;
        m_pc      = pc;
        m_addr    = addr;
        m_old     = old;
        m_ecall   = ec;
        m_mret    = mr && !ec;
        m_is_csr  = !ec && !mr && (f3 % 4 != 0);
        m_we      = 0;
        m_data    = 0;
        operand   = (f3 >= 4) ? 64'(idx) : val;
        if (m_is_csr) begin
            case (f3 % 4)
                1: begin m_data = operand;        m_we = 1;        end
                2: begin m_data = old | operand;  m_we = (idx != 0); end
                default: begin m_data = old & ~operand; m_we = (idx != 0); end
            endcase
        end
        if (ec) begin
            m_target = mtvec - (mtvec % 4);
            m_traps  = m_traps + 1;
        end else if (mr)
            m_target = mepc;
        else
            m_target = pc + 4;
    endtask

    task automatic check_writer(input string ph);
        chk({ph, "_counter"}, wr_inst_counter, m_cnt);
        chk({ph, "_wr_pc"},   wr_pc, m_pc);
        chk({ph, "_ecall"},   64'(wr_ecall), 64'(m_ecall));
        chk({ph, "_mret"},    64'(wr_mret), 64'(m_mret));
        chk({ph, "_we"},      64'(wr_csr_write_enable), 64'(m_we));
        chk({ph, "_plain"},   64'(wr_plain), 64'(m_we));
        chk({ph, "_addr"},    64'(wr_csr_dest_addr), 64'(m_addr));
        if (m_is_csr)
            chk({ph, "_wdata"}, wr_csr_write_data, m_data);
`ifdef CSR_COMMIT_PERF_EN
        chk({ph, "_perf_commits"}, perf_commits, m_commits);
        chk({ph, "_perf_traps"},   perf_traps, m_traps);
`endif
    endtask

    task automatic scramble();
        in_pc = rnd64(); in_rs1_val = rnd64(); csr_old_value = rnd64();
        csr_mtvec = rnd64(); csr_mepc = rnd64(); in_rs1_idx = 5'($urandom);
        in_funct3 = 3'($urandom); in_csr_addr = 12'($urandom);
        in_is_ecall = 1'($urandom); in_is_mret = 1'($urandom);
    endtask

    // One full transaction, entered and left at a negedge in IDLE.
    task automatic issue(input logic [63:0] pc, input logic [2:0] f3,
                         input logic [11:0] addr, input logic [4:0] idx,
                         input logic [63:0] val, input logic ec, input logic mr,
                         input logic [63:0] old, input logic [63:0] mtvec,
                         input logic [63:0] mepc);
        int n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk("ready_wait", 64'(in_ready), 64'd1);
        in_pc = pc; in_funct3 = f3; in_csr_addr = addr; in_rs1_idx = idx;
        in_rs1_val = val; in_is_ecall = ec; in_is_mret = mr;
        csr_old_value = old; csr_mtvec = mtvec; csr_mepc = mepc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_accept(pc, f3, addr, idx, val, ec, mr, old, mtvec, mepc);
        scramble();
        @(negedge clk);
        chk("apply_ready", 64'(in_ready), 64'd0);
        chk("apply_flush", 64'(flush), 64'd0);
        chk("apply_redir", 64'(redirect_valid), 64'd0);
        check_writer("apply");
        @(negedge clk);
        chk("flush_flush", 64'(flush), 64'd1);
        chk("flush_redir_valid", 64'(redirect_valid), 64'd1);
        chk("flush_redir_pc", redirect_pc, m_target);
        chk("flush_ready", 64'(in_ready), 64'd0);
        chk("flush_rd_valid", 64'(rd_valid), 64'(m_is_csr));
        if (m_is_csr) chk("flush_rd_value", rd_value, m_old);
        for (int i = 1; i < FLUSH_CYCLES; i++) begin
            @(negedge clk);
            chk("flush_hold", 64'(flush), 64'd1);
            chk("flush_rd_once", 64'(rd_valid), 64'd0);
        end
        @(negedge clk);
        chk("idle_ready", 64'(in_ready), 64'd1);
        chk("idle_flush", 64'(flush), 64'd0);
        chk("idle_redir", 64'(redirect_valid), 64'd0);
        chk("idle_rd_valid", 64'(rd_valid), 64'd0);
        check_writer("idle");
    endtask

    task automatic check_all_zero(input string ph);
        chk({ph, "_flush"},    64'(flush), 64'd0);
        chk({ph, "_redir_v"},  64'(redirect_valid), 64'd0);
        chk({ph, "_redir_pc"}, redirect_pc, 64'd0);
        chk({ph, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({ph, "_rd_value"}, rd_value, 64'd0);
        chk({ph, "_wdata0"},   wr_csr_write_data, 64'd0);
        check_writer(ph);
    endtask

    initial begin
        logic [2:0] f3;
        logic [4:0] idx;
        rst = 1'b1; in_valid = 1'b1;
        scramble();
        model_reset();
        @(negedge clk);
        chk("reset_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("reset_ready_held", 64'(in_ready), 64'd0);
        check_all_zero("reset");
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 64'(in_ready), 64'd1);
        check_all_zero("post_reset");

        // Directed cases.
        issue(64'h8000_0000, 3'b001, 12'h340, 5'd5, 64'hDEAD, 0, 0, 64'h1234, 0, 0);
        issue(64'h8000_0004, 3'b010, 12'h300, 5'd0, 64'h55, 0, 0, 64'hF0, 0, 0);
        issue(64'h8000_0008, 3'b111, 12'h344, 5'd3, 64'h0, 0, 0, 64'hFF, 0, 0);
        issue(64'h8000_0010, 3'b000, 12'h000, 5'd0, 64'h0, 1, 0, 64'h0,
              64'h8000_0103, 64'h0);
        issue(64'h8000_0020, 3'b000, 12'h302, 5'd0, 64'h0, 0, 1, 64'h0,
              64'h0, 64'h8000_0014);
        issue(64'h8000_0030, 3'b000, 12'h000, 5'd0, 64'h0, 1, 1, 64'h0,
              64'h8000_0202, 64'h9999);
        issue(64'h8000_0040, 3'b100, 12'h123, 5'd7, 64'h1, 0, 0, 64'hAB, 0, 0);
        issue(64'hFFFF_FFFF_FFFF_FFFC, 3'b110, 12'h7C0, 5'd31, 64'h0, 0, 0,
              64'h1, 0, 0);

        // Randomized transactions.
        for (int t = 0; t < 150; t++) begin
            f3  = 3'($urandom);
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            issue(rnd64(), f3, 12'($urandom), idx, rnd64(),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  rnd64(), rnd64(), rnd64());
        end

        // in_valid held high: accepts exactly every 2+FLUSH_CYCLES cycles.
        in_pc = 64'h8000_1000; in_funct3 = 3'b001; in_csr_addr = 12'h340;
        in_rs1_idx = 5'd1; in_rs1_val = 64'h77; in_is_ecall = 0; in_is_mret = 0;
        csr_old_value = 64'h11; csr_mtvec = 0; csr_mepc = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 3 * (2 + FLUSH_CYCLES); k++) begin
            @(posedge clk); #1;
            if (k % (2 + FLUSH_CYCLES) == 0)
                model_accept(in_pc, in_funct3, in_csr_addr, in_rs1_idx, in_rs1_val,
                             0, 0, csr_old_value, 0, 0);
            chk("b2b_counter", wr_inst_counter, m_cnt);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle_ready", 64'(in_ready), 64'd1);
        check_writer("b2b");

        // Reset during APPLY aborts with no redirect.
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_all_zero("mid_rst");
        chk("mid_rst_ready_after", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("mid_rst_no_flush", 64'(flush), 64'd0);
        chk("mid_rst_no_redir", 64'(redirect_valid), 64'd0);

        issue(64'h8000_2000, 3'b011, 12'h341, 5'd2, 64'h0F, 0, 0, 64'hFF, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/csr_commit.md
Name: csr_commit

Overview:
- Serialising commit stage directly upstream of the CSR register file.
- Accepts one SYSTEM-class instruction at a time from writeback: CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI, ECALL, MRET.
- Computes the read-modify-write value and drives the CSR writer record, whose inst_counter bump triggers the CSR file's update.
- Then flushes the pipeline and redirects fetch, so later instructions observe the updated CSR state.

Parameters:
XLEN, 64, data/pc width
FLUSH_CYCLES, 1, cycles flush/redirect_valid held high (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  instruction offered
in_ready  out  1  stage can accept
in_pc  in  XLEN  pc of instruction
in_funct3  in  3  CSR op encoding (RISC-V funct3)
in_csr_addr  in  12  target CSR
in_rs1_idx  in  5  rs1 index / zimm field
in_rs1_val  in  XLEN  rs1 value
in_is_ecall  in  1  ECALL
in_is_mret  in  1  MRET
csr_old_value  in  XLEN  current value of in_csr_addr (combinational read mux)
csr_mtvec  in  XLEN  current mtvec
csr_mepc  in  XLEN  current mepc
wr_inst_counter  out  XLEN  writer commit tag
wr_pc  out  XLEN  writer pc
wr_ecall  out  1  writer ecall
wr_mret  out  1  writer mret
wr_csr_write_enable  out  1  writer write enable
wr_plain  out  1  writer plain CSR op
wr_csr_dest_addr  out  12  writer address
wr_csr_write_data  out  XLEN  writer data
rd_valid  out  1  rd_value valid (1-cycle pulse)
rd_value  out  XLEN  old CSR value for rd writeback
flush  out  1  pipeline flush
redirect_valid  out  1  fetch redirect
redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset: all outputs 0; wr_inst_counter=0; state IDLE. in_ready=0 during the reset cycle and 1 in the first cycle after. rst mid-operation aborts to IDLE with no redirect.
- FSM: IDLE -> APPLY -> FLUSH -> IDLE.
- IDLE:
  - in_ready=1.
  - Handshake: in_valid&&in_ready at edge E0 latches all inputs and increments wr_inst_counter by 1 (wraps at 2^XLEN).
  - The writer fields registered at E0 are held stable until the next accept.
- Source operand: src = funct3[2] ? zero-extend(in_rs1_idx) : in_rs1_val.
- New value, by funct3[1:0]:
  - 01 RW: src.
  - 10 RS: old|src.
  - 11 RC: old&~src.
- Write enable:
  - wr_csr_write_enable=1 and wr_plain=1 for RW always.
  - Same for RS/RC only when in_rs1_idx!=0.
  - Otherwise both are 0.
- funct3[1:0]=00 with neither ecall nor mret: no-op commit (counter still increments, no write). Redirect to pc+4.
- ECALL: wr_ecall=1, write enable 0, wr_pc=in_pc.
- MRET: wr_mret=1.
- ECALL and MRET together: ECALL wins.
- APPLY: exactly 1 cycle, in_ready=0; the CSR file performs its update at E1.
- FLUSH:
  - Lasts FLUSH_CYCLES cycles; flush=1 and redirect_valid=1 throughout; in_ready=0.
  - rd_valid=1 in the first FLUSH cycle only, and only for CSR ops, with rd_value = latched csr_old_value.
- redirect_pc:
  - ECALL: latched csr_mtvec with bits[1:0] cleared.
  - MRET: latched csr_mepc.
  - Otherwise: latched in_pc+4 (XLEN wrap).
- mtvec/mepc are latched at accept. Serialisation guarantees any prior CSR write has already landed.
- Throughput: one instruction per 2+FLUSH_CYCLES cycles. in_valid during busy cycles is ignored (no accept).

Optional Feature:
- Macro: CSR_COMMIT_PERF_EN.
- Defined: adds output perf_commits (XLEN), a count of accepted instructions.
  - Reset 0; +1 on each accept, same edge as wr_inst_counter; wraps.
  - Separate perf_traps (XLEN) counts ECALL accepts.
- Undefined: both ports and their counters are absent.

Test Plan:
- CSRRW 0x340, rs1_val=0xDEAD, old=0x1234 -> counter 0->1, write_data=0xDEAD, we=1, plain=1; FLUSH cycle: rd_value=0x1234, redirect_pc=pc+4.
- CSRRS rs1_idx=0, old=0xF0 -> we=0; rd_value=0xF0; counter still increments.
- CSRRCI zimm=0x3, old=0xFF -> write_data=0xFC, we=1.
- ECALL at pc=0x8000_0010, mtvec=0x8000_0103 -> wr_ecall=1, wr_pc=0x8000_0010, redirect_pc=0x8000_0100, flush high 1 cycle.
- MRET, mepc=0x8000_0014 -> wr_mret=1, redirect_pc=0x8000_0014.
- Back-to-back in_valid: second accepted exactly 3 cycles after first (FLUSH_CYCLES=1). rst asserted in APPLY -> next cycle all outputs 0, no redirect.
